pong_referee: RTL and testbench
===============================

PONG_REFEREE -- requirements
Module: pong_referee

Interface
REQ-001 Parameters: SCREEN_Y=100 (playfield height, px); BALL_SIZE=5 (ball edge, px); PADDLE_XL=4 (x of left paddle face); PADDLE_XR=95 (x of right paddle face); PADDLE_H=20 (paddle height, px); TICK_DIV=4 (clocks per ball move); SERVE_DELAY=8 (ticks before serve); WIN_SCORE=5 (points to win).
REQ-002 Port list, one per line: name  direction  width  meaning.
clock  in  1  single system clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  level; begins a game from IDLE or GAME_OVER.
ball_x  in  10  ball left edge, unsigned.
ball_y  in  10  ball top edge, unsigned.
paddle_l_y  in  10  left paddle top edge, unsigned.
paddle_r_y  in  10  right paddle top edge, unsigned.
bounce  out  2  00 none, 01 paddle, 10 wall; 11 never driven.
ball_rst  out  1  one-cycle pulse; re-centres the ball.
move_en  out  1  one-cycle pulse; ball advances one step.
score_l  out  4  left player score.
score_r  out  4  right player score.
game_over  out  1  high while in GAME_OVER.
state  out  3  current FSM state, for debug.
REQ-003 Reset is synchronous and active-high, with one clock domain, clock.

Function
REQ-004 FSM states: IDLE=0, SERVE=1, PLAY=2, SCORED=3, GAME_OVER=4; codes 5-7 go to IDLE on the next clock.
REQ-005 IDLE: start=1 -> SERVE; scores cleared on this transition.
REQ-006 Tick counter: counts 0..TICK_DIV-1 and wraps; one tick = the cycle on which the count is TICK_DIV-1; runs in SERVE and PLAY; cleared on every state change.
REQ-007 SERVE: ball_rst=1 on the first cycle in SERVE only; after SERVE_DELAY ticks -> PLAY.
REQ-008 PLAY: move_en is a copy of the tick (one cycle high every TICK_DIV clocks; the first pulse comes TICK_DIV clocks after entering PLAY); move_en=0 in every other state.
REQ-009 Collision checks run only on PLAY tick cycles; the result is registered, so bounce is high for exactly one cycle, the cycle after the tick.
REQ-010 Wall hit: ball_y==0 or ball_y+BALL_SIZE>=SCREEN_Y -> bounce=10.
REQ-011 Paddle hit, left: ball_x<=PADDLE_XL and vertical overlap. Vertical overlap: ball_y+BALL_SIZE>paddle_l_y and ball_y<paddle_l_y+PADDLE_H. Result: bounce=01.
REQ-012 Paddle hit, right: ball_x+BALL_SIZE>=PADDLE_XR and the same overlap against paddle_r_y -> bounce=01.
REQ-013 Corner case, paddle and wall true on the same tick: bounce=01; the wall event is dropped.
REQ-014 Cooldown: on the tick right after a tick that issued a given bounce code, that same code is suppressed (bounce=00); the other code is still allowed.
REQ-015 Miss, left: ball_x<=PADDLE_XL and no left overlap -> score_r+1 -> SCORED; no bounce issued.
REQ-016 Miss, right: mirror of REQ-015; score_l+1 -> SCORED.
REQ-017 Score width: all sums use 11-bit intermediates, so no wrap at 1023.
REQ-018 Score limit: scores saturate at WIN_SCORE; they never exceed it.
REQ-019 SCORED lasts exactly 1 cycle: a score equal to WIN_SCORE -> GAME_OVER; otherwise -> SERVE.
REQ-020 GAME_OVER: game_over=1; scores held; start=1 -> clear scores, -> SERVE.
REQ-021 A start held high continuously does not re-trigger inside SERVE or PLAY.
REQ-022 All outputs are registered, with no combinational path from inputs to outputs.

Reset
REQ-023 Reset=1 at a rising edge gives, on that edge: state=IDLE; counters=0; score_l=score_r=0; bounce=00; ball_rst=0; move_en=0; game_over=0; cooldown flags cleared.
REQ-024 Reset overrides start and any collision in the same cycle.
REQ-025 Reset in any state, including mid-PLAY, aborts the rally within one clock; no score change.

Verification
REQ-026 Serve timing: reset, then start=1 -> ball_rst high 1 cycle on SERVE entry. PLAY is entered 32 clocks later (8 ticks x 4). First move_en comes 4 clocks after PLAY entry.
REQ-027 Wall bounce: PLAY, ball_y=0, ball_x=50 at a tick -> bounce=10 for one cycle. Re-apply the same at the next tick -> bounce=00 (cooldown).
REQ-028 Paddle hit beats wall: ball_x=4, ball_y=0, paddle_l_y=0 at a tick -> bounce=01; no wall bounce that tick; scores unchanged.
REQ-029 Miss and game over: ball_x=4, ball_y=60, paddle_l_y=0 -> score_r 0->1, then SCORED -> SERVE. Repeat to score_r=5 -> GAME_OVER, game_over=1. start=1 -> scores=0, SERVE.
REQ-030 Reset mid-rally: reset=1 mid-PLAY with score_l=3 -> next edge state=0, score_l=0, move_en=0.
REQ-031 Illegal state: force state=6 -> IDLE on the next clock.

Source files
------------

// File: rtl/pong_referee.sv
// Pong referee: serve/play/score sequencing, tick-paced ball moves and
// registered collision decisions (wall, paddle, miss) with per-code cooldown.
package pong_referee_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_SCORED    = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    BNC_NONE   = 2'b00,
    BNC_PADDLE = 2'b01,
    BNC_WALL   = 2'b10
  } bounce_t;
endpackage

module pong_referee
  import pong_referee_pkg::*;
#(
  parameter int unsigned SCREEN_Y    = 100,
  parameter int unsigned BALL_SIZE   = 5,
  parameter int unsigned PADDLE_XL   = 4,
  parameter int unsigned PADDLE_XR   = 95,
  parameter int unsigned PADDLE_H    = 20,
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned SERVE_DELAY = 8,
  parameter int unsigned WIN_SCORE   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [1:0] bounce,
  output logic       ball_rst,
  output logic       move_en,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [TW-1:0] C_TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] C_SERVE_LAST = SW'(SERVE_DELAY - 1);
  localparam logic [10:0]   C_BALL   = 11'(BALL_SIZE);
  localparam logic [10:0]   C_SCREEN = 11'(SCREEN_Y);
  localparam logic [10:0]   C_XL     = 11'(PADDLE_XL);
  localparam logic [10:0]   C_XR     = 11'(PADDLE_XR);
  localparam logic [10:0]   C_PH     = 11'(PADDLE_H);
  localparam logic [10:0]   C_WIN    = 11'(WIN_SCORE);
  localparam logic [3:0]    C_WIN4   = 4'(WIN_SCORE);

  state_t          r_state, w_state_nxt;
  bounce_t         r_bounce, w_bounce_nxt;
  logic [TW-1:0]   r_tick_cnt;
  logic [SW-1:0]   r_serve_cnt;
  logic [3:0]      r_score_l, r_score_r;
  logic            r_ball_rst, r_move_en, r_game_over;
  logic            r_cool_wall, r_cool_paddle;

  logic [10:0] w_bx, w_by, w_pl, w_pr, w_inc_l, w_inc_r;
  logic [3:0]  w_sat_l, w_sat_r;
  logic        w_run, w_tick, w_play_tick, w_wall, w_ovl_l, w_ovl_r;
  logic        w_at_l, w_at_r, w_miss_l, w_miss_r, w_miss, w_paddle;

  // Geometry is evaluated in 11 bits so ball_y+BALL_SIZE cannot wrap.
  assign w_bx = {1'b0, ball_x};
  assign w_by = {1'b0, ball_y};
  assign w_pl = {1'b0, paddle_l_y};
  assign w_pr = {1'b0, paddle_r_y};

  assign w_run       = (r_state == ST_SERVE) || (r_state == ST_PLAY);
  assign w_tick      = w_run && (r_tick_cnt == C_TICK_LAST);
  assign w_play_tick = (r_state == ST_PLAY) && w_tick;

  assign w_wall   = (w_by == 11'd0) || (w_by + C_BALL >= C_SCREEN);
  assign w_ovl_l  = (w_by + C_BALL > w_pl) && (w_by < w_pl + C_PH);
  assign w_ovl_r  = (w_by + C_BALL > w_pr) && (w_by < w_pr + C_PH);
  assign w_at_l   = (w_bx <= C_XL);
  assign w_at_r   = (w_bx + C_BALL >= C_XR);
  assign w_miss_l = w_at_l && !w_ovl_l;
  assign w_miss_r = !w_at_l && w_at_r && !w_ovl_r;
  assign w_miss   = w_miss_l || w_miss_r;
  assign w_paddle = (w_at_l && w_ovl_l) || (!w_at_l && w_at_r && w_ovl_r);

  assign w_inc_l = {7'd0, r_score_l} + 11'd1;
  assign w_inc_r = {7'd0, r_score_r} + 11'd1;
  assign w_sat_l = (w_inc_l >= C_WIN) ? C_WIN4 : w_inc_l[3:0];
  assign w_sat_r = (w_inc_r >= C_WIN) ? C_WIN4 : w_inc_r[3:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:      if (start) w_state_nxt = ST_SERVE;
      ST_SERVE:     if (w_tick && r_serve_cnt == C_SERVE_LAST) w_state_nxt = ST_PLAY;
      ST_PLAY:      if (w_tick && w_miss) w_state_nxt = ST_SCORED;
      ST_SCORED:    w_state_nxt = (r_score_l == C_WIN4 || r_score_r == C_WIN4)
                                  ? ST_GAME_OVER : ST_SERVE;
      ST_GAME_OVER: if (start) w_state_nxt = ST_SERVE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // A paddle contact always masks a simultaneous wall contact, even when cooled down.
  always_comb begin
    w_bounce_nxt = BNC_NONE;
    if (w_play_tick && !w_miss) begin
      if (w_paddle) begin
        if (!r_cool_paddle) w_bounce_nxt = BNC_PADDLE;
      end else if (w_wall && !r_cool_wall) begin
        w_bounce_nxt = BNC_WALL;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_tick_cnt    <= '0;
      r_serve_cnt   <= '0;
      r_score_l     <= '0;
      r_score_r     <= '0;
      r_bounce      <= BNC_NONE;
      r_ball_rst    <= 1'b0;
      r_move_en     <= 1'b0;
      r_game_over   <= 1'b0;
      r_cool_wall   <= 1'b0;
      r_cool_paddle <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bounce    <= w_bounce_nxt;
      r_ball_rst  <= (w_state_nxt == ST_SERVE) && (r_state != ST_SERVE);
      r_move_en   <= w_play_tick && (w_state_nxt == ST_PLAY);
      r_game_over <= (w_state_nxt == ST_GAME_OVER);

      if (w_state_nxt != r_state || !w_run || w_tick) r_tick_cnt <= '0;
      else                                             r_tick_cnt <= r_tick_cnt + 1'b1;

      if (w_state_nxt != r_state || r_state != ST_SERVE) r_serve_cnt <= '0;
      else if (w_tick)                                   r_serve_cnt <= r_serve_cnt + 1'b1;

      if (r_state != ST_PLAY) begin
        r_cool_wall   <= 1'b0;
        r_cool_paddle <= 1'b0;
      end else if (w_play_tick) begin
        r_cool_wall   <= (w_bounce_nxt == BNC_WALL);
        r_cool_paddle <= (w_bounce_nxt == BNC_PADDLE);
      end

      if ((r_state == ST_IDLE || r_state == ST_GAME_OVER) && start) begin
        r_score_l <= '0;
        r_score_r <= '0;
      end else if (w_play_tick && w_miss_l) begin
        r_score_r <= w_sat_r;
      end else if (w_play_tick && w_miss_r) begin
        r_score_l <= w_sat_l;
      end
    end
  end

  assign state     = r_state;
  assign bounce    = r_bounce;
  assign ball_rst  = r_ball_rst;
  assign move_en   = r_move_en;
  assign score_l   = r_score_l;
  assign score_r   = r_score_r;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_pong_referee.sv
// Self-checking bench for pong_referee: serve timing, a table of collision
// vectors with a scoreboard, misses to game over, reset mid-rally, illegal state.
module tb_pong_referee;
  import pong_referee_pkg::*;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic [1:0] bounce;
  logic       ball_rst, move_en, game_over;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  pong_referee dut (
    .clock(clock), .reset(reset), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .bounce(bounce), .ball_rst(ball_rst), .move_en(move_en),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] x, y, pl, pr;
    int         bnc;
  } vec_t;

  typedef struct {
    string name;
    int    bnc, sl, sr, st, mv;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  exp_t   sb_q[$];
  vec_t   vecs[16];
  state_t ill_state;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [9:0] x, input logic [9:0] y,
                       input logic [9:0] pl, input logic [9:0] pr);
    ball_x = x; ball_y = y; paddle_l_y = pl; paddle_r_y = pr;
  endtask

  task automatic wait_move_en(input string name);
    int n = 0;
    while (move_en !== 1'b1 && n < 64) begin
      step(1);
      n++;
    end
    check(name, int'(move_en), 1);
  endtask

  // Entered on a move_en cycle: the next tick is three clocks later, its result one after.
  task automatic apply_vec(input vec_t v, input string name);
    exp_t e;
    drive(v.x, v.y, v.pl, v.pr);
    sb_q.push_back('{name, v.bnc, 0, 0, int'(ST_PLAY), 1});
    step(4);
    e = sb_q.pop_front();
    check({e.name, ".bounce"}, int'(bounce), e.bnc);
    check({e.name, ".score_l"}, int'(score_l), e.sl);
    check({e.name, ".score_r"}, int'(score_r), e.sr);
    check({e.name, ".state"}, int'(state), e.st);
    check({e.name, ".move_en"}, int'(move_en), e.mv);
  endtask

  task automatic score_point(input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] pl, input logic [9:0] pr,
                             input int exp_l, input int exp_r, input bit last);
    exp_t e;
    drive(x, y, pl, pr);
    sb_q.push_back('{"miss", 0, exp_l, exp_r, int'(ST_SCORED), 0});
    step(4);
    e = sb_q.pop_front();
    check("miss.state", int'(state), e.st);
    check("miss.score_l", int'(score_l), e.sl);
    check("miss.score_r", int'(score_r), e.sr);
    check("miss.bounce", int'(bounce), e.bnc);
    check("miss.move_en", int'(move_en), e.mv);
    drive(10'd50, 10'd50, 10'd40, 10'd40);
    step(1);
    if (last) begin
      check("over.state", int'(state), int'(ST_GAME_OVER));
      check("over.game_over", int'(game_over), 1);
    end else begin
      check("reserve.state", int'(state), int'(ST_SERVE));
      check("reserve.ball_rst", int'(ball_rst), 1);
      wait_move_en("reserve.move_en");
    end
  endtask

  initial begin
    vecs[0]  = '{10'd50, 10'd50, 10'd40, 10'd40, 0};  // open field
    vecs[1]  = '{10'd5,  10'd94, 10'd40, 10'd40, 0};  // just short of left face and floor
    vecs[2]  = '{10'd50, 10'd0,  10'd40, 10'd40, 2};  // top wall
    vecs[3]  = '{10'd50, 10'd0,  10'd40, 10'd40, 0};  // wall cooldown
    vecs[4]  = '{10'd50, 10'd0,  10'd40, 10'd40, 2};  // cooldown expired
    vecs[5]  = '{10'd50, 10'd95, 10'd40, 10'd40, 0};  // bottom wall, still cooled
    vecs[6]  = '{10'd50, 10'd50, 10'd40, 10'd40, 0};
    vecs[7]  = '{10'd50, 10'd95, 10'd40, 10'd40, 2};  // bottom wall exact
    vecs[8]  = '{10'd50, 10'd50, 10'd40, 10'd40, 0};
    vecs[9]  = '{10'd4,  10'd0,  10'd0,  10'd40, 1};  // paddle beats wall
    vecs[10] = '{10'd50, 10'd0,  10'd40, 10'd40, 2};  // other code allowed
    vecs[11] = '{10'd90, 10'd50, 10'd40, 10'd40, 1};  // right paddle
    vecs[12] = '{10'd4,  10'd50, 10'd40, 10'd40, 0};  // paddle cooldown
    vecs[13] = '{10'd0,  10'd36, 10'd40, 10'd40, 1};  // left overlap lower edge
    vecs[14] = '{10'd50, 10'd50, 10'd40, 10'd40, 0};
    vecs[15] = '{10'd94, 10'd59, 10'd40, 10'd40, 1};  // right overlap upper edge

    reset = 1'b1;
    start = 1'b0;
    drive(10'd50, 10'd50, 10'd40, 10'd40);
    step(2);
    check("rst.state", int'(state), 0);
    check("rst.score_l", int'(score_l), 0);
    check("rst.score_r", int'(score_r), 0);
    check("rst.bounce", int'(bounce), 0);
    check("rst.ball_rst", int'(ball_rst), 0);
    check("rst.move_en", int'(move_en), 0);
    check("rst.game_over", int'(game_over), 0);

    reset = 1'b0;
    start = 1'b1;
    step(1);
    check("serve.state", int'(state), int'(ST_SERVE));
    check("serve.ball_rst", int'(ball_rst), 1);
    step(1);
    check("serve.ball_rst_drop", int'(ball_rst), 0);
    step(30);
    check("serve.still_serving", int'(state), int'(ST_SERVE));
    step(1);
    check("serve.play_entry", int'(state), int'(ST_PLAY));
    check("serve.no_early_move", int'(move_en), 0);
    start = 1'b0;
    step(3);
    check("play.move_en_before", int'(move_en), 0);
    step(1);
    check("play.first_move_en", int'(move_en), 1);

    for (int i = 0; i < 16; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    for (int p = 1; p <= 3; p++)
      score_point(10'd90, 10'd50, 10'd40, 10'd0, p, 0, 1'b0);

    drive(10'd50, 10'd0, 10'd40, 10'd40);
    start = 1'b1;
    step(3);
    reset = 1'b1;
    step(1);
    check("midrst.state", int'(state), 0);
    check("midrst.score_l", int'(score_l), 0);
    check("midrst.move_en", int'(move_en), 0);
    check("midrst.bounce", int'(bounce), 0);
    step(1);
    check("midrst.start_overridden", int'(state), 0);
    reset = 1'b0;
    drive(10'd50, 10'd50, 10'd40, 10'd40);
    step(1);
    check("restart.state", int'(state), int'(ST_SERVE));
    start = 1'b0;
    wait_move_en("restart.move_en");

    for (int p = 1; p <= 5; p++)
      score_point(10'd4, 10'd60, 10'd0, 10'd40, 0, p, p == 5);
    step(3);
    check("over.held_state", int'(state), int'(ST_GAME_OVER));
    check("over.held_score_r", int'(score_r), 5);

    start = 1'b1;
    step(1);
    check("newgame.state", int'(state), int'(ST_SERVE));
    check("newgame.score_r", int'(score_r), 0);
    check("newgame.game_over", int'(game_over), 0);
    check("newgame.ball_rst", int'(ball_rst), 1);
    start = 1'b0;

    step(2);
    ill_state = state_t'(3'd6);
    force dut.r_state = ill_state;
    #2;
    release dut.r_state;
    step(1);
    check("illegal.state", int'(state), int'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
